// File: rtl/btn_conditioner.sv
// Push-button conditioner: two-flop synchroniser, debounce FSM,
// press/release/long-press/auto-repeat single-cycle events.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HMAX = (LONG_CYCLES > REPEAT_CYCLES) ?
                        LONG_CYCLES : REPEAT_CYCLES;
  localparam int HW   = $clog2(HMAX + 1);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] REP_LAST = HW'(REPEAT_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HMAX);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    REPEAT,
    RELEASE_WAIT
  } state_t;

  state_t          state;
  logic            sync_q1;
  logic            btn_sync;
  logic [DW-1:0]   deb_cnt;
  logic [HW-1:0]   hold_cnt;
  logic            long_seen;
  logic [DW-1:0]   deb_inc;
  logic [HW-1:0]   hold_inc;

  // Saturating increments: counters never wrap.
  assign deb_inc = (deb_cnt == DEB_LAST) ?
                   deb_cnt : deb_cnt + DW'(1);
  assign hold_inc = (hold_cnt == HOLD_MAX) ?
                    hold_cnt : hold_cnt + HW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1  <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      sync_q1  <= btn_raw;
      btn_sync <= sync_q1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      deb_cnt       <= '0;
      hold_cnt      <= '0;
      long_seen     <= 1'b0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      unique case (state)
        IDLE: begin
          btn_level <= 1'b0;
          if (btn_sync) begin
            state   <= PRESS_WAIT;
            deb_cnt <= DW'(1);
          end
        end
        PRESS_WAIT: begin
          if (!btn_sync) begin
            state <= IDLE;
          end else if (deb_cnt == DEB_LAST) begin
            state       <= HELD;
            btn_level   <= 1'b1;
            press_pulse <= 1'b1;
            hold_cnt    <= '0;
            long_seen   <= 1'b0;
          end else begin
            deb_cnt <= deb_inc;
          end
        end
        HELD: begin
          if (!btn_sync) begin
            state   <= RELEASE_WAIT;
            deb_cnt <= DW'(1);
          end else if (hold_cnt == LONG_LAST) begin
            state      <= REPEAT;
            long_pulse <= 1'b1;
            long_seen  <= 1'b1;
            hold_cnt   <= '0;
          end else begin
            hold_cnt <= hold_inc;
          end
        end
        REPEAT: begin
          if (!btn_sync) begin
            state   <= RELEASE_WAIT;
            deb_cnt <= DW'(1);
          end else if (hold_cnt == REP_LAST) begin
            repeat_pulse <= 1'b1;
            hold_cnt     <= '0;
          end else begin
            hold_cnt <= hold_inc;
          end
        end
        RELEASE_WAIT: begin
          // hold_cnt stays frozen so a glitch only delays the cadence.
          if (btn_sync) begin
            state <= long_seen ? REPEAT : HELD;
          end else if (deb_cnt == DEB_LAST) begin
            state         <= IDLE;
            btn_level     <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            deb_cnt <= deb_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
